// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  // Detector FSM states; encodings are fixed so they read the same in any dump.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StSearch = 2'd2
  } state_e;

  // Widest pattern the mask helper supports; PAT_W must not exceed this.
  localparam int unsigned MaxPatW = 64;

  // Mask with the low 'len' bits set; selects the live part of history/pattern.
  function automatic logic [MaxPatW-1:0] len_mask(input int unsigned len);
    logic [MaxPatW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxPatW; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register with saturating fill counter. Exposes the post-shift
// view so the compare can include the bit arriving in the current cycle.
module seq_det_hist #(
  parameter int unsigned PatW = 8,
  parameter int unsigned LenW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            shift_i,
  input  logic            bit_i,
  input  logic [LenW-1:0] len_i,
  output logic [PatW-1:0] hist_shift_o,
  output logic [LenW-1:0] fill_shift_o
);

  logic [PatW-1:0] hist_q, hist_d;
  logic [LenW-1:0] fill_q, fill_d;

  // Post-shift view: what history/fill become if the current bit is accepted.
  always_comb begin
    hist_shift_o = {hist_q[PatW-2:0], bit_i};
    fill_shift_o = (fill_q < len_i) ? fill_q + LenW'(1) : fill_q;
  end

  // Clear wins over shift so a match in non-overlap mode empties the history.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_shift_o;
      fill_d = fill_shift_o;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-programmable pattern,
// length and overlap mode. Optional saturating match counter is enabled by
// defining SEQ_DET_MATCH_COUNT_EN; otherwise match_cnt is tied to zero.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1),
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               cfg_err_q, cfg_err_d;
  logic               match_q, match_d;

  logic               cfg_legal;
  logic               shift_en;
  logic               hit;
  logic               hist_clear;
  logic [MaxPatW-1:0] mask;
  logic [PAT_W-1:0]   hist_shift;
  logic [LEN_W-1:0]   fill_shift;

  seq_det_hist #(
    .PatW (PAT_W),
    .LenW (LEN_W)
  ) u_hist (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (hist_clear),
    .shift_i      (shift_en),
    .bit_i        (in_bit),
    .len_i        (len_q),
    .hist_shift_o (hist_shift),
    .fill_shift_o (fill_shift)
  );

  // Compare post-shift history against the pattern over the low len bits only.
  always_comb begin
    cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    mask       = len_mask(32'(len_q));
    shift_en   = in_valid && !cfg_load && (state_q != StIdle);
    hit        = shift_en && (fill_shift == len_q) &&
                 ((MaxPatW'(hist_shift ^ pattern_q) & mask) == '0);
    hist_clear = cfg_load || (hit && !overlap_q);
  end

  // Next-state: config latch, FSM sequencing and the registered match pulse.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_err_q;
    match_d   = hit;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      cfg_err_d = !cfg_legal;
      match_d   = 1'b0;
      state_d   = cfg_legal ? StFill : StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StFill: begin
          if (shift_en && (fill_shift == len_q)) begin
            state_d = (hit && !overlap_q) ? StFill : StSearch;
          end
        end
        StSearch: begin
          if (hit && !overlap_q) state_d = StFill;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Configuration, FSM and match registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      cfg_err_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cfg_err_q <= cfg_err_d;
      match_q   <= match_d;
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of matches; moves on the same edge that raises match.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Match counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

endmodule
